// File: rtl/reg_file_wb.sv
// Integer register file with write-back handshake, two registered read ports
// and a per-register pending scoreboard used for RAW hazard stalls.
module reg_file_wb #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [XLEN-1:0]   wr_data,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic              wr_data_valid,
    output logic              wr_ack,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [XLEN-1:0]   rd_data_a,
    output logic [XLEN-1:0]   rd_data_b,
    output logic              rd_data_valid,
    output logic              rd_pending_a,
    output logic              rd_pending_b,
    input  logic              issue_valid,
    input  logic [ADDR_W-1:0] issue_rd
);

    localparam int NREGS = 2 ** ADDR_W;

    typedef enum logic {
        W_IDLE = 1'b0,
        W_ACK  = 1'b1
    } wstate_t;

    wstate_t           state_reg;
    logic              wr_ack_reg;
    logic              commit;
    logic [XLEN-1:0]   regs [NREGS];
    logic [NREGS-1:0]  pending;
    logic [XLEN-1:0]   rd_data_a_reg;
    logic [XLEN-1:0]   rd_data_b_reg;
    logic              rd_data_valid_reg;
    logic              bypass_a;
    logic              bypass_b;

    // A write only commits from W_IDLE; the held valid during W_ACK is ignored.
    assign commit = (state_reg == W_IDLE) && wr_data_valid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg  <= W_IDLE;
            wr_ack_reg <= 1'b0;
        end else begin
            case (state_reg)
                W_IDLE: begin
                    if (wr_data_valid) begin
                        wr_ack_reg <= 1'b1;
                        state_reg  <= W_ACK;
                    end
                end
                W_ACK: begin
                    wr_ack_reg <= 1'b0;
                    state_reg  <= W_IDLE;
                end
                default: begin
                    wr_ack_reg <= 1'b0;
                    state_reg  <= W_IDLE;
                end
            endcase
        end
    end

    // x0 is hardwired: no storage and never pending.
    assign regs[0]    = '0;
    assign pending[0] = 1'b0;

    genvar gi;
    generate
        for (gi = 1; gi < NREGS; gi++) begin : g_reg
            logic [XLEN-1:0] q_reg;
            logic            pend_reg;
            logic            hit_wr;
            logic            hit_issue;

            assign hit_wr    = commit && (wr_addr == ADDR_W'(gi));
            assign hit_issue = issue_valid && (issue_rd == ADDR_W'(gi));

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    q_reg <= '0;
                end else if (hit_wr) begin
                    q_reg <= wr_data;
                end
            end

            // A newer issue to the same register outranks the clearing write.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    pend_reg <= 1'b0;
                end else if (hit_issue) begin
                    pend_reg <= 1'b1;
                end else if (hit_wr) begin
                    pend_reg <= 1'b0;
                end
            end

            assign regs[gi]    = q_reg;
            assign pending[gi] = pend_reg;
        end
    endgenerate

    assign bypass_a = commit && (wr_addr == rd_addr_a) && (rd_addr_a != '0);
    assign bypass_b = commit && (wr_addr == rd_addr_b) && (rd_addr_b != '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_data_a_reg     <= '0;
            rd_data_b_reg     <= '0;
            rd_data_valid_reg <= 1'b0;
        end else if (rd_req) begin
            rd_data_a_reg     <= bypass_a ? wr_data : regs[rd_addr_a];
            rd_data_b_reg     <= bypass_b ? wr_data : regs[rd_addr_b];
            rd_data_valid_reg <= 1'b1;
        end else begin
            rd_data_valid_reg <= 1'b0;
        end
    end

    assign wr_ack        = wr_ack_reg;
    assign rd_data_a     = rd_data_a_reg;
    assign rd_data_b     = rd_data_b_reg;
    assign rd_data_valid = rd_data_valid_reg;
    assign rd_pending_a  = pending[rd_addr_a];
    assign rd_pending_b  = pending[rd_addr_b];

endmodule

// File: tb/tb_reg_file_wb.sv
// Directed self-checking bench for reg_file_wb: handshake, reads, bypass,
// scoreboard priority, x0 handling and asynchronous reset mid-operation.
module tb_reg_file_wb;

    localparam int XLEN   = 32;
    localparam int ADDR_W = 5;

    logic              clk;
    logic              reset;
    logic [XLEN-1:0]   wr_data;
    logic [ADDR_W-1:0] wr_addr;
    logic              wr_data_valid;
    logic              wr_ack;
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr_a;
    logic [ADDR_W-1:0] rd_addr_b;
    logic [XLEN-1:0]   rd_data_a;
    logic [XLEN-1:0]   rd_data_b;
    logic              rd_data_valid;
    logic              rd_pending_a;
    logic              rd_pending_b;
    logic              issue_valid;
    logic [ADDR_W-1:0] issue_rd;

    int checks = 0;
    int errors = 0;

    reg_file_wb #(.XLEN(XLEN), .ADDR_W(ADDR_W)) dut (
        .clk           (clk),
        .reset         (reset),
        .wr_data       (wr_data),
        .wr_addr       (wr_addr),
        .wr_data_valid (wr_data_valid),
        .wr_ack        (wr_ack),
        .rd_req        (rd_req),
        .rd_addr_a     (rd_addr_a),
        .rd_addr_b     (rd_addr_b),
        .rd_data_a     (rd_data_a),
        .rd_data_b     (rd_data_b),
        .rd_data_valid (rd_data_valid),
        .rd_pending_a  (rd_pending_a),
        .rd_pending_b  (rd_pending_b),
        .issue_valid   (issue_valid),
        .issue_rd      (issue_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running required finished");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    // Advance one rising edge and settle 1 ns past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [ADDR_W-1:0] a, input logic [XLEN-1:0] d);
        wr_addr       = a;
        wr_data       = d;
        wr_data_valid = 1'b1;
        tick();
        check("wr_ack_write", {31'b0, wr_ack}, 32'd1);
        wr_data_valid = 1'b0;
        tick();
    endtask

    initial begin
        reset         = 1'b1;
        wr_data       = '0;
        wr_addr       = '0;
        wr_data_valid = 1'b0;
        rd_req        = 1'b0;
        rd_addr_a     = '0;
        rd_addr_b     = '0;
        issue_valid   = 1'b0;
        issue_rd      = '0;

        repeat (3) tick();
        check("rst_wr_ack",    {31'b0, wr_ack},        32'd0);
        check("rst_rd_valid",  {31'b0, rd_data_valid}, 32'd0);
        check("rst_pending_a", {31'b0, rd_pending_a},  32'd0);
        check("rst_pending_b", {31'b0, rd_pending_b},  32'd0);
        check("rst_rd_data_a", rd_data_a,              32'd0);
        reset = 1'b0;

        // All registers read zero after reset.
        for (int i = 1; i < 32; i++) begin
            rd_req    = 1'b1;
            rd_addr_a = ADDR_W'(i);
            rd_addr_b = ADDR_W'(32 - i);
            tick();
            check("rst_read_a", rd_data_a, 32'd0);
            check("rst_read_b", rd_data_b, 32'd0);
        end
        check("read_valid", {31'b0, rd_data_valid}, 32'd1);
        rd_req = 1'b0;
        tick();
        check("read_valid_drop", {31'b0, rd_data_valid}, 32'd0);

        // Handshake: ack one cycle after valid, held valid ignored in ack cycle.
        wr_addr       = 5'd5;
        wr_data       = 32'h2;
        wr_data_valid = 1'b1;
        #1;
        check("ack_before_edge", {31'b0, wr_ack}, 32'd0);
        tick();
        check("ack_first", {31'b0, wr_ack}, 32'd1);
        wr_data = 32'h99;
        tick();
        check("ack_second", {31'b0, wr_ack}, 32'd0);
        wr_data_valid = 1'b0;
        tick();
        check("ack_idle", {31'b0, wr_ack}, 32'd0);
        rd_req    = 1'b1;
        rd_addr_a = 5'd5;
        tick();
        check("read_x5", rd_data_a, 32'h2);
        rd_req = 1'b0;
        tick();
        check("hold_x5", rd_data_a, 32'h2);

        // Scoreboard set by issue, cleared by commit.
        issue_valid = 1'b1;
        issue_rd    = 5'd5;
        tick();
        issue_valid = 1'b0;
        rd_addr_a   = 5'd5;
        #1;
        check("pending_x5_set", {31'b0, rd_pending_a}, 32'd1);
        wr_addr       = 5'd5;
        wr_data       = 32'hDEAD_BEEF;
        wr_data_valid = 1'b1;
        #1;
        check("pending_no_bypass", {31'b0, rd_pending_a}, 32'd1);
        tick();
        check("pending_x5_clr", {31'b0, rd_pending_a}, 32'd0);
        wr_data_valid = 1'b0;
        tick();

        // Same-edge write and read: bypass to port B.
        wr_addr       = 5'd7;
        wr_data       = 32'h1234;
        wr_data_valid = 1'b1;
        rd_req        = 1'b1;
        rd_addr_a     = 5'd5;
        rd_addr_b     = 5'd7;
        tick();
        check("bypass_b",       rd_data_b,              32'h1234);
        check("bypass_other_a", rd_data_a,              32'hDEAD_BEEF);
        check("bypass_valid",   {31'b0, rd_data_valid}, 32'd1);
        wr_data_valid = 1'b0;
        rd_req        = 1'b0;
        tick();

        // x0: issue never pends, write acked but discarded.
        issue_valid = 1'b1;
        issue_rd    = 5'd0;
        tick();
        issue_valid = 1'b0;
        rd_addr_a   = 5'd0;
        rd_addr_b   = 5'd0;
        #1;
        check("x0_pending_a", {31'b0, rd_pending_a}, 32'd0);
        check("x0_pending_b", {31'b0, rd_pending_b}, 32'd0);
        do_write(5'd0, 32'hFFFF_FFFF);
        rd_req    = 1'b1;
        rd_addr_a = 5'd0;
        tick();
        check("x0_read", rd_data_a, 32'd0);
        rd_req = 1'b0;
        tick();
        wr_addr       = 5'd0;
        wr_data       = 32'hFFFF_FFFF;
        wr_data_valid = 1'b1;
        rd_req        = 1'b1;
        rd_addr_a     = 5'd0;
        tick();
        check("x0_no_bypass", rd_data_a, 32'd0);
        check("x0_ack",       {31'b0, wr_ack}, 32'd1);
        wr_data_valid = 1'b0;
        rd_req        = 1'b0;
        tick();

        // Same-edge issue and commit on x9: set wins.
        do_write(5'd9, 32'hABCD);
        issue_valid   = 1'b1;
        issue_rd      = 5'd9;
        wr_addr       = 5'd9;
        wr_data       = 32'h5555;
        wr_data_valid = 1'b1;
        rd_req        = 1'b1;
        rd_addr_a     = 5'd9;
        rd_addr_b     = 5'd9;
        tick();
        issue_valid = 1'b0;
        rd_req      = 1'b0;
        #1;
        check("x9_pending_kept", {31'b0, rd_pending_b},  32'd1);
        check("x9_ack",          {31'b0, wr_ack},        32'd1);
        check("x9_rd_valid",     {31'b0, rd_data_valid}, 32'd1);

        // Asynchronous reset while in the ack cycle.
        reset = 1'b1;
        #1;
        check("async_wr_ack",   {31'b0, wr_ack},        32'd0);
        check("async_rd_valid", {31'b0, rd_data_valid}, 32'd0);
        check("async_pending",  {31'b0, rd_pending_b},  32'd0);
        wr_data_valid = 1'b0;
        tick();
        reset = 1'b0;
        rd_req    = 1'b1;
        rd_addr_a = 5'd9;
        rd_addr_b = 5'd7;
        tick();
        check("x9_cleared", rd_data_a, 32'd0);
        check("x7_cleared", rd_data_b, 32'd0);
        rd_req = 1'b0;

        // FSM must be back in W_IDLE: a new write is acked after one cycle.
        do_write(5'd3, 32'h77);
        rd_req    = 1'b1;
        rd_addr_a = 5'd3;
        tick();
        check("read_x3", rd_data_a, 32'h77);
        rd_req = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_file_wb.md
Name: reg_file_wb

Overview:
- Integer register file and write-back stage directly downstream of the ALU.
- Consumes the ALU register-write handshake (data/addr/valid -> ack).
- Serves two registered read ports to the operand-fetch stage.
- Keeps a per-register pending scoreboard so issue logic can stall on RAW hazards.

Parameters:
XLEN, 32, data width of every register and data port
ADDR_W, 5, register address width; register count is 2**ADDR_W

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-high reset
wr_data  input  XLEN  write-back data (driven by ALU reg_wr_data)
wr_addr  input  ADDR_W  destination register (ALU reg_wr_addr)
wr_data_valid  input  1  write request, held until wr_ack seen
wr_ack  output  1  one-cycle registered acknowledge of committed write
rd_req  input  1  read request, samples rd_addr_a/rd_addr_b
rd_addr_a  input  ADDR_W  source register A
rd_addr_b  input  ADDR_W  source register B
rd_data_a  output  XLEN  registered read data A
rd_data_b  output  XLEN  registered read data B
rd_data_valid  output  1  read data valid, one cycle after rd_req
rd_pending_a  output  1  rd_addr_a pending (combinational on current inputs)
rd_pending_b  output  1  rd_addr_b pending (combinational on current inputs)
issue_valid  input  1  an instruction with a register destination is issued
issue_rd  input  ADDR_W  destination register of the issued instruction

Behaviour:
- Reset (asynchronous): all registers = 0, pending bits = 0, wr_ack = 0, rd_data_a/b = 0, rd_data_valid = 0, write FSM = W_IDLE.
- Register x0 is hardwired to 0.
  - Writes to x0 complete the full handshake (ack issued), but the data is discarded.
  - Reads of x0 return 0.
  - The pending bit of x0 is never set.
- Write FSM, two states:
  - W_IDLE: on a rising edge with wr_data_valid=1, commit regs[wr_addr] <= wr_data, clear pending[wr_addr], set wr_ack <= 1, go to W_ACK.
  - W_ACK: wr_ack <= 0, go to W_IDLE. wr_data_valid is ignored in this state, because the producer still holds valid during the ack cycle. No second write occurs.
  - Throughput is one write per 2 cycles. Latency from valid to ack is 1 cycle.
- Read port:
  - On a rising edge with rd_req=1, register rd_data_a/b from the addressed registers and set rd_data_valid <= 1.
  - With rd_req=0, rd_data_valid <= 0 and rd_data_a/b hold their values.
- Write-to-read bypass:
  - Condition: a write commits on the same edge as a read sample, to the same non-zero address.
  - Required response: the read returns the new wr_data.
- Scoreboard:
  - issue_valid=1 sets pending[issue_rd] on the edge (unless issue_rd=0).
  - A committed write clears pending[wr_addr].
  - If set and clear hit the same register on the same edge, the set wins, because a newer producer has been issued.
- rd_pending_a/b = pending[rd_addr_a/b].
  - Pure lookup of current state; no bypass of the same-cycle clear.
  - Always 0 for address 0.
- Reset mid-operation: an asserted wr_ack or rd_data_valid drops immediately. An in-flight write that has not yet committed is lost. The producer must re-present it after reset.
- No X propagation: rd_data_* outputs are always driven from registered state.

Test Plan:
- Reset for 3 cycles -> wr_ack=0, rd_data_valid=0, rd_pending_a/b=0. Read of x1..x31 returns 0.
- wr_addr=5, wr_data=32'h2, valid held until ack -> wr_ack=1 exactly one cycle after valid first seen, then 0. Valid still high in the ack cycle causes no second write. Later read of x5 returns 2.
- issue_valid with issue_rd=5, then rd_addr_a=5 -> rd_pending_a=1. Write x5=32'hDEAD_BEEF -> rd_pending_a=0 after the commit edge.
- Same-edge write x7=32'h1234 and rd_req with rd_addr_b=7 -> next cycle rd_data_b=32'h1234, rd_data_valid=1.
- Write x0=32'hFFFF_FFFF -> ack asserted, read of x0 returns 0. issue_rd=0 never sets rd_pending.
- Same-edge issue_rd=9 and commit to x9 -> pending[9] stays 1. Reset asserted during W_ACK -> wr_ack=0 immediately, FSM in W_IDLE, x9 data cleared to 0.
